mem_stage: RTL

- Memory-access stage directly downstream of the execute-stage ALU.
- Takes the ALU result (effective address or computed value), store data and the instruction fields.
- For loads and stores, runs a request/grant/response transaction on the data-memory port, aligns store data and byte enables, and aligns and sign- or zero-extends load data.
- Passes every other instruction through to writeback with a valid/ready handshake.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_load_align.sv | 34 +++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage_pkg: shared opcodes, funct3 codes, FSM states, helpers  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mem_stage_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam int unsigned BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    OUT  = 2'd3
  } mem_state_t;

  // Unsupported funct3 encodings are reported as misaligned so they never reach memory.
  function automatic logic is_misaligned(input logic is_store, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b1;
    if (is_store) begin
      case (funct3)
        FUNCT3_SB: mis = 1'b0;
        FUNCT3_SH: mis = addr_lo[0];
        FUNCT3_SW: mis = |addr_lo;
        default:   mis = 1'b1;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: mis = 1'b0;
        FUNCT3_LH, FUNCT3_LHU: mis = addr_lo[0];
        FUNCT3_LW:             mis = |addr_lo;
        default:               mis = 1'b1;
      endcase
    end
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_align: shifts the read word to the addressed lane and        |
// | sign/zero-extends byte and halfword loads. Rev 1.0                |
// +------------------------------------------------------------------+
module load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 8 * BE_WIDTH
) (
  input  logic [DWIDTH-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] data
);

  logic [15:0] w_shifted;

  assign w_shifted = 16'(rdata >> {addr, 3'b000});

  always_comb begin
    data = rdata;
    case (funct3)
      FUNCT3_LB:  data = {{(DWIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      FUNCT3_LBU: data = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
      FUNCT3_LH:  data = {{(DWIDTH-16){w_shifted[15]}}, w_shifted};
      FUNCT3_LHU: data = {{(DWIDTH-16){1'b0}}, w_shifted};
      FUNCT3_LW:  data = rdata;
      default:    data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage: memory-access stage; runs req/gnt/rvalid transactions  |
// | for loads/stores and passes other results to writeback. Rev 1.0   |
// +------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 8 * BE_WIDTH,
  parameter int unsigned AWIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [AWIDTH-1:0]   pc_i,
  input  logic [DWIDTH-1:0]   alu_res_i,
  input  logic [DWIDTH-1:0]   rs2_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic [4:0]          rd_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [AWIDTH-1:0]   pc_o,
  output logic [4:0]          rd_o,
  output logic [DWIDTH-1:0]   res_o,
  output logic                misalign_o
);

  localparam int unsigned c_BE_W = DWIDTH / 8;

  mem_state_t r_state;
  mem_state_t w_state_next;

  logic [AWIDTH-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_is_store;

  logic              w_accept;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misaligned;
  logic              w_go_mem;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_load_data;
  logic [DWIDTH-1:0] w_st_wdata;
  logic [c_BE_W-1:0] w_st_be;

  assign w_addr       = AWIDTH'(alu_res_i);
  assign w_is_load    = (opcode_i == OPCODE_LOAD);
  assign w_is_store   = (opcode_i == OPCODE_STORE);
  assign w_is_mem     = w_is_load | w_is_store;
  assign w_misaligned = is_misaligned(w_is_store, funct3_i, w_addr[1:0]);
  assign w_go_mem     = w_is_mem & ~w_misaligned;
  assign w_accept     = valid_i & ready_o;

  // Loads drive all byte enables and zero write data.
  always_comb begin
    w_st_be    = '1;
    w_st_wdata = '0;
    if (w_is_store) begin
      case (funct3_i)
        FUNCT3_SB: begin
          w_st_be    = c_BE_W'(1) << w_addr[1:0];
          w_st_wdata = {c_BE_W{rs2_i[7:0]}};
        end
        FUNCT3_SH: begin
          w_st_be    = w_addr[1] ? c_BE_W'(4'b1100) : c_BE_W'(4'b0011);
          w_st_wdata = {(DWIDTH/16){rs2_i[15:0]}};
        end
        default: begin
          w_st_be    = '1;
          w_st_wdata = rs2_i;
        end
      endcase
    end
  end

  load_align #(
    .DWIDTH (DWIDTH)
  ) u_load_align (
    .rdata  (mem_rdata_i),
    .addr   (r_addr[1:0]),
    .funct3 (r_funct3),
    .data   (w_load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (w_accept) w_state_next = w_go_mem ? REQ : OUT;
      end
      REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = r_is_store;
        if (mem_gnt_i) w_state_next = r_is_store ? OUT : RESP;
      end
      RESP: begin
        if (mem_rvalid_i) w_state_next = OUT;
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Stores and misaligned accesses report the address; it is captured at accept and held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_funct3    <= '0;
      r_is_store  <= 1'b0;
      pc_o        <= '0;
      rd_o        <= '0;
      res_o       <= '0;
      misalign_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            pc_o       <= pc_i;
            rd_o       <= rd_i;
            r_addr     <= w_addr;
            r_funct3   <= funct3_i;
            r_is_store <= w_is_store;
            misalign_o <= w_is_mem & w_misaligned;
            res_o      <= w_is_mem ? DWIDTH'(w_addr) : alu_res_i;
            if (w_go_mem) begin
              mem_addr_o  <= {w_addr[AWIDTH-1:2], 2'b00};
              mem_be_o    <= w_st_be;
              mem_wdata_o <= w_st_wdata;
            end
          end
        end
        RESP: begin
          if (mem_rvalid_i) res_o <= w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
